if_fetch_unit: RTL

- Instruction-fetch stage; the producer side of the IF/ID pipeline register.
- Owns the PC register and next-PC selection (sequential, redirect, exception vectors).
- Latches interrupt requests and presents the PC and IRQ flag that IF/ID captures, obeying the same stall signal IF/ID uses.
- Drives the instruction-memory address; instruction data goes straight from memory to IF/ID.

---
 rtl/cpu_pipe_pkg.sv | 38 +++
 rtl/irq_edge_latch.sv | 41 ++++
 rtl/if_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline constants and helpers for the fetch stage.
// Provides PC width, kernel-bit position, default vectors and next-PC helpers.
package cpu_pipe_pkg;

   localparam int unsigned PC_W       = 32;
   localparam int unsigned KERNEL_BIT = 31;
   localparam int unsigned OFF_W      = PC_W - 1;

   localparam logic [PC_W-1:0] RESET_PC_DEF  = 32'h8000_0000;
   localparam logic [PC_W-1:0] ILLOP_VEC_DEF = 32'h8000_0004;
   localparam logic [PC_W-1:0] IRQ_VEC_DEF   = 32'h8000_0008;

   typedef logic [PC_W-1:0] pc_t;

   // Redirect request from the resolving stage.
   typedef struct packed {
      logic valid;
      logic is_jr;
      pc_t  target;
   } redirect_t;

   // Sequential successor: kernel bit is sticky, the offset wraps within 31 bits.
   function automatic pc_t pc_plus4(input pc_t pc);
      logic [OFF_W-1:0] off;
      off = pc[OFF_W-1:0] + OFF_W'(4);
      return {pc[KERNEL_BIT], off};
   endfunction

   // Redirect destination: word aligned; only register targets may change privilege.
   function automatic pc_t redirect_pc(input pc_t cur, input pc_t tgt, input logic is_jr);
      pc_t  aligned;
      logic kbit;
      aligned = tgt & ~PC_W'(3);
      kbit    = is_jr ? tgt[KERNEL_BIT] : cur[KERNEL_BIT];
      return {kbit, aligned[OFF_W-1:0]};
   endfunction

endpackage : cpu_pipe_pkg

// File: rtl/irq_edge_latch.sv
// Interrupt request edge detector and pending latch.
// A rising edge of irq_i sets the pending bit; only an accept clears it.
// An edge arriving in the same cycle as an accept is dropped.
module irq_edge_latch (
   input  logic clk,
   input  logic rst_n,
   input  logic irq_i,
   input  logic accept_i,
   output logic pend_o
);

   logic irq_q;
   logic pend_q, pend_d;
   logic rise_c;

   assign rise_c = irq_i & ~irq_q;

   // Pending bit next state: accept dominates a coincident edge.
   always_comb begin
      pend_d = pend_q;
      if (accept_i) begin
         pend_d = 1'b0;
      end else if (rise_c) begin
         pend_d = 1'b1;
      end
   end

   // Previous-level flop and pending flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q  <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         irq_q  <= irq_i;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule : irq_edge_latch

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and IRQ presentation.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise fetch_cnt/stall_cnt read as zero and no counter flops exist.
module if_fetch_unit
   import cpu_pipe_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [PC_W-1:0] ILLOP_VEC = ILLOP_VEC_DEF,
   parameter logic [PC_W-1:0] IRQ_VEC   = IRQ_VEC_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [PC_W-1:0] redirect_target,
   input  logic            redirect_is_jr,
   input  logic            illop,
   input  logic            irq,
   output logic [PC_W-1:0] pc_out,
   output logic [PC_W-1:0] pc_plus4_out,
   output logic            irq_out,
   output logic [PC_W-1:0] epc_out,
   output logic [31:0]     fetch_cnt,
   output logic [31:0]     stall_cnt
);

   pc_t       pc_q, pc_d;
   pc_t       epc_q, epc_d;
   logic      irq_out_q;
   logic      irq_pend;
   logic      accept_c;
   redirect_t redir;

   assign redir = {redirect_valid, redirect_is_jr, redirect_target};

   // Interrupts are taken only in user mode on a quiet, unstalled cycle.
   assign accept_c = irq_pend & ~stall & ~pc_q[KERNEL_BIT] & ~illop & ~redir.valid;

   irq_edge_latch u_irq_latch (
      .clk      (clk),
      .rst_n    (reset),
      .irq_i    (irq),
      .accept_i (accept_c),
      .pend_o   (irq_pend)
   );

   // Next-PC priority: illop, redirect, IRQ accept, stall hold, sequential.
   always_comb begin
      pc_d  = pc_q;
      epc_d = epc_q;
      if (illop) begin
         pc_d  = ILLOP_VEC;
         epc_d = pc_q;
      end else if (redir.valid) begin
         pc_d = redirect_pc(pc_q, redir.target, redir.is_jr);
      end else if (accept_c) begin
         pc_d  = IRQ_VEC;
         epc_d = pc_q;
      end else if (!stall) begin
         pc_d = pc_plus4(pc_q);
      end
   end

   // PC, EPC and interrupt-taken flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= RESET_PC;
         epc_q     <= '0;
         irq_out_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         epc_q     <= epc_d;
         irq_out_q <= accept_c;
      end
   end

   assign pc_out       = pc_q;
   assign pc_plus4_out = pc_plus4(pc_q);
   assign irq_out      = irq_out_q;
   assign epc_out      = epc_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Fetch counts every unstalled cycle; stall counts stalls not overridden by illop/redirect.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (!stall) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (stall & ~illop & ~redir.valid) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // Counter registers, wrapping naturally at 2^32.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign fetch_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule : if_fetch_unit
